// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle: ID/EX/MEM hazard sources in, pipeline stall/flush and mult/div sequencing out.
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       ID_Rs;
    logic [4:0]       ID_Rt;
    logic             ID_UsesRs;
    logic             ID_UsesRt;
    logic             ID_Branch;
    logic             ID_BranchTaken;
    logic             ID_Jump;
    logic             ID_JumpReg;
    logic             ID_MulDiv;
    logic             ID_ReadHiLo;
    logic             EX_MemRead;
    logic             EX_RegWrite;
    logic [4:0]       EX_WriteReg;
    logic             MEM_MemRead;
    logic [4:0]       MEM_WriteReg;
    logic             PC_Write;
    logic             Stall_FD;
    logic             Flush_FD;
    logic             Flush_DE;
    logic             MD_Start;
    logic             MD_Done;
    logic             MD_Busy;
    logic [CNT_W-1:0] StallCount;
    logic [CNT_W-1:0] FlushCount;

    modport master (
        output ID_Rs, ID_Rt, ID_UsesRs, ID_UsesRt, ID_Branch, ID_BranchTaken,
               ID_Jump, ID_JumpReg, ID_MulDiv, ID_ReadHiLo,
               EX_MemRead, EX_RegWrite, EX_WriteReg, MEM_MemRead, MEM_WriteReg,
        input  PC_Write, Stall_FD, Flush_FD, Flush_DE, MD_Start, MD_Done, MD_Busy,
               StallCount, FlushCount
    );

    modport slave (
        input  ID_Rs, ID_Rt, ID_UsesRs, ID_UsesRt, ID_Branch, ID_BranchTaken,
               ID_Jump, ID_JumpReg, ID_MulDiv, ID_ReadHiLo,
               EX_MemRead, EX_RegWrite, EX_WriteReg, MEM_MemRead, MEM_WriteReg,
        output PC_Write, Stall_FD, Flush_FD, Flush_DE, MD_Start, MD_Done, MD_Busy,
               StallCount, FlushCount
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush scheduler for a 5-stage pipeline plus iterative mult/div sequencer and saturating perf counters.
// Control outputs are combinational (zero latency); counters and mult/div state are registered.
module pipe_hazard_ctrl #(
    parameter int MD_CYCLES = 32,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    pipe_hazard_ctrl_if.slave hz
);
    localparam int MW = $clog2(MD_CYCLES + 1);

    typedef enum logic {IDLE, RUN} md_state_t;

    md_state_t        r_state;
    md_state_t        w_state_nxt;
    logic [MW-1:0]    r_md_cnt;
    logic [MW-1:0]    w_md_cnt_nxt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic w_rs_read, w_ex_match, w_mem_match, w_ctl_br;
    logic w_lu, w_bx, w_bm, w_hl, w_sd, w_stall;
    logic w_busy, w_done, w_start, w_flush_fd, w_stall_fd;

    // jr/jalr read rs in ID even when the decoder does not flag UsesRs
    assign w_rs_read   = hz.ID_UsesRs | hz.ID_JumpReg;
    assign w_ex_match  = (hz.EX_WriteReg != 5'd0) &&
                         ((w_rs_read && (hz.EX_WriteReg == hz.ID_Rs)) ||
                          (hz.ID_UsesRt && (hz.EX_WriteReg == hz.ID_Rt)));
    assign w_mem_match = (hz.MEM_WriteReg != 5'd0) &&
                         ((w_rs_read && (hz.MEM_WriteReg == hz.ID_Rs)) ||
                          (hz.ID_UsesRt && (hz.MEM_WriteReg == hz.ID_Rt)));
    assign w_ctl_br    = hz.ID_Branch | hz.ID_JumpReg;

    assign w_busy  = (r_state == RUN);
    assign w_done  = w_busy && (r_md_cnt == MW'(1));

    assign w_lu    = hz.EX_MemRead & w_ex_match;
    assign w_bx    = w_ctl_br & hz.EX_RegWrite & w_ex_match;
    assign w_bm    = w_ctl_br & hz.MEM_MemRead & w_mem_match;
    assign w_hl    = hz.ID_ReadHiLo & w_busy;
    assign w_sd    = hz.ID_MulDiv & w_busy & ~w_done;
    assign w_stall = w_lu | w_bx | w_bm | w_hl | w_sd;

    assign w_stall_fd = ~reset & w_stall;
    assign w_flush_fd = ~reset & ~w_stall &
                        ((hz.ID_Branch & hz.ID_BranchTaken) | hz.ID_Jump);
    assign w_start    = ~reset & hz.ID_MulDiv & ~w_stall;

    assign hz.PC_Write   = reset | ~w_stall;
    assign hz.Stall_FD   = w_stall_fd;
    assign hz.Flush_DE   = w_stall_fd;
    assign hz.Flush_FD   = w_flush_fd;
    assign hz.MD_Start   = w_start;
    assign hz.MD_Done    = ~reset & w_done;
    assign hz.MD_Busy    = ~reset & w_busy;
    assign hz.StallCount = r_stall_cnt;
    assign hz.FlushCount = r_flush_cnt;

    // A start while RUN can only coincide with the done cycle, so it reloads for back-to-back issue
    always_comb begin
        w_state_nxt  = r_state;
        w_md_cnt_nxt = r_md_cnt;
        case (r_state)
            IDLE: begin
                if (w_start) begin
                    w_state_nxt  = RUN;
                    w_md_cnt_nxt = MW'(MD_CYCLES);
                end
            end
            RUN: begin
                if (w_start) begin
                    w_md_cnt_nxt = MW'(MD_CYCLES);
                end else if (w_done) begin
                    w_state_nxt  = IDLE;
                    w_md_cnt_nxt = '0;
                end else begin
                    w_md_cnt_nxt = r_md_cnt - MW'(1);
                end
            end
            default: begin
                w_state_nxt  = IDLE;
                w_md_cnt_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_md_cnt <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_md_cnt <= w_md_cnt_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall_fd && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            if (w_flush_fd && (r_flush_cnt != '1))
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: expected control vectors queued per cycle, compared at negedge.
module tb_pipe_hazard_ctrl;
    localparam int CW = 4;
    localparam int SAT = (1 << CW) - 1;

    // {PC_Write, Stall_FD, Flush_FD, Flush_DE, MD_Start, MD_Done, MD_Busy}
    localparam logic [6:0] C_IDLE  = 7'b1000000;
    localparam logic [6:0] C_STALL = 7'b0101000;
    localparam logic [6:0] C_FLUSH = 7'b1010000;
    localparam logic [6:0] C_START = 7'b1000100;
    localparam logic [6:0] C_DONE  = 7'b0000010;
    localparam logic [6:0] C_BUSY  = 7'b0000001;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad = 0;
    int   sc = 0;
    int   fc = 0;
    logic [6:0] exp_q[$];

    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.CNT_W(CW)) hz ();

    pipe_hazard_ctrl #(.MD_CYCLES(32), .CNT_W(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz.slave)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, want, $time);
        end
    endtask

    task automatic clr();
        hz.ID_Rs = 5'd0; hz.ID_Rt = 5'd0; hz.ID_UsesRs = 1'b0; hz.ID_UsesRt = 1'b0;
        hz.ID_Branch = 1'b0; hz.ID_BranchTaken = 1'b0; hz.ID_Jump = 1'b0;
        hz.ID_JumpReg = 1'b0; hz.ID_MulDiv = 1'b0; hz.ID_ReadHiLo = 1'b0;
        hz.EX_MemRead = 1'b0; hz.EX_RegWrite = 1'b0; hz.EX_WriteReg = 5'd0;
        hz.MEM_MemRead = 1'b0; hz.MEM_WriteReg = 5'd0;
    endtask

    // Inputs are set by the caller just after posedge; outputs are checked at the following negedge.
    task automatic step(input string tag, input logic [6:0] e);
        logic [6:0] obs;
        logic [6:0] x;
        exp_q.push_back(e);
        @(negedge clk);
        obs = {hz.PC_Write, hz.Stall_FD, hz.Flush_FD, hz.Flush_DE,
               hz.MD_Start, hz.MD_Done, hz.MD_Busy};
        x = exp_q.pop_front();
        chk(tag, 32'(obs), 32'(x));
        chk({tag, "_scnt"}, 32'(hz.StallCount), 32'(sc));
        chk({tag, "_fcnt"}, 32'(hz.FlushCount), 32'(fc));
        if (reset) begin
            sc = 0;
            fc = 0;
        end else begin
            if (x[5] && sc < SAT) sc++;
            if (x[4] && fc < SAT) fc++;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        clr();
        @(posedge clk);
        #1;
        // outputs forced while in reset, even with start/jump requests present
        hz.ID_MulDiv = 1'b1; hz.ID_Jump = 1'b1;
        step("rst_force", C_IDLE);
        step("rst_force2", C_IDLE);
        reset = 1'b0;
        clr();
        step("idle", C_IDLE);

        // load-use
        hz.EX_MemRead = 1'b1; hz.EX_RegWrite = 1'b1; hz.EX_WriteReg = 5'd8;
        hz.ID_Rs = 5'd8; hz.ID_UsesRs = 1'b1;
        step("lu_stall", C_STALL);
        hz.EX_MemRead = 1'b0; hz.EX_RegWrite = 1'b0; hz.EX_WriteReg = 5'd0;
        step("lu_go", C_IDLE);
        clr();
        // matching reg but not read -> no hazard
        hz.EX_MemRead = 1'b1; hz.EX_RegWrite = 1'b1; hz.EX_WriteReg = 5'd8;
        hz.ID_Rs = 5'd8; hz.ID_UsesRs = 1'b0;
        step("lu_unused", C_IDLE);
        clr();

        // branch after load: bx then bm, then taken flush
        hz.EX_MemRead = 1'b1; hz.EX_RegWrite = 1'b1; hz.EX_WriteReg = 5'd9;
        hz.ID_Rs = 5'd9; hz.ID_UsesRs = 1'b1; hz.ID_Rt = 5'd3; hz.ID_UsesRt = 1'b1;
        hz.ID_Branch = 1'b1; hz.ID_BranchTaken = 1'b1;
        step("br_bx", C_STALL);
        hz.EX_MemRead = 1'b0; hz.EX_RegWrite = 1'b0; hz.EX_WriteReg = 5'd0;
        hz.MEM_MemRead = 1'b1; hz.MEM_WriteReg = 5'd9;
        step("br_bm", C_STALL);
        hz.MEM_MemRead = 1'b0; hz.MEM_WriteReg = 5'd0;
        step("br_taken", C_FLUSH);
        clr();
        step("br_after", C_IDLE);

        // branch after ALU producer on rt: single stall
        hz.EX_RegWrite = 1'b1; hz.EX_WriteReg = 5'd5;
        hz.ID_Rt = 5'd5; hz.ID_UsesRt = 1'b1; hz.ID_Branch = 1'b1;
        step("br_alu", C_STALL);
        hz.EX_RegWrite = 1'b0; hz.EX_WriteReg = 5'd0; hz.MEM_WriteReg = 5'd5;
        step("br_alu_go", C_IDLE);
        clr();
        // ALU producer, non-branch consumer: forwarding, no stall
        hz.EX_RegWrite = 1'b1; hz.EX_WriteReg = 5'd5; hz.ID_Rs = 5'd5; hz.ID_UsesRs = 1'b1;
        step("alu_fwd", C_IDLE);
        clr();
        // jr reads rs implicitly
        hz.EX_RegWrite = 1'b1; hz.EX_WriteReg = 5'd7; hz.ID_Rs = 5'd7;
        hz.ID_Jump = 1'b1; hz.ID_JumpReg = 1'b1;
        step("jr_stall", C_STALL);
        hz.EX_RegWrite = 1'b0; hz.EX_WriteReg = 5'd0;
        step("jr_go", C_FLUSH);
        clr();

        // $0 never matches
        hz.EX_MemRead = 1'b1; hz.EX_RegWrite = 1'b1; hz.EX_WriteReg = 5'd0;
        hz.ID_UsesRs = 1'b1; hz.ID_UsesRt = 1'b1; hz.ID_Branch = 1'b1;
        step("r0_nostall", C_IDLE);
        clr();
        hz.ID_Jump = 1'b1;
        step("j_flush", C_FLUSH);
        clr();

        // mult then mflo
        hz.ID_MulDiv = 1'b1;
        step("md_start", C_START);
        hz.ID_MulDiv = 1'b0; hz.ID_ReadHiLo = 1'b1;
        for (int i = 1; i < 32; i++) step("mflo_stall", C_STALL | C_BUSY);
        step("mflo_done", C_STALL | C_BUSY | C_DONE);
        step("mflo_go", C_IDLE);
        clr();

        // back-to-back mult
        hz.ID_MulDiv = 1'b1;
        step("md2_start", C_START);
        for (int i = 1; i < 32; i++) step("md2_stall", C_STALL | C_BUSY);
        step("md2_reissue", C_START | C_DONE | C_BUSY);
        hz.ID_MulDiv = 1'b0;
        for (int i = 1; i < 32; i++) step("md2_run", C_IDLE | C_BUSY);
        step("md2_done", C_IDLE | C_BUSY | C_DONE);
        step("md2_idle", C_IDLE);

        // reset mid-RUN abandons the operation
        hz.ID_MulDiv = 1'b1;
        step("md3_start", C_START);
        hz.ID_MulDiv = 1'b0;
        for (int i = 1; i < 10; i++) step("md3_run", C_IDLE | C_BUSY);
        reset = 1'b1;
        step("md3_rst", C_IDLE);
        reset = 1'b0;
        for (int i = 0; i < 40; i++) step("md3_abandon", C_IDLE);

        // counter saturation
        hz.EX_MemRead = 1'b1; hz.EX_RegWrite = 1'b1; hz.EX_WriteReg = 5'd8;
        hz.ID_Rs = 5'd8; hz.ID_UsesRs = 1'b1;
        for (int i = 0; i < 20; i++) step("sat_stall", C_STALL);
        clr();
        step("sat_idle", C_IDLE);
        chk("sat_final", 32'(hz.StallCount), 32'(SAT));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush scheduler for the 5-stage F|D|E|M|W pipeline.
- Drives PC write-enable, IF/ID stall and flush, and ID/EX bubble insertion.
- Detects load-use hazards, branch/jr operand hazards (branches resolve in ID), and HI/LO hazards.
- Sequences the iterative multiply/divide unit with an internal cycle counter; keeps saturating stall and flush performance counters.

Parameters:
- MD_CYCLES, 32: cycles the mult/div unit is busy per operation (>=2).
- CNT_W, 16: width of the performance counters.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- ID_Rs  in  5  rs field of instruction in ID
- ID_Rt  in  5  rt field of instruction in ID
- ID_UsesRs  in  1  ID instruction reads rs
- ID_UsesRt  in  1  ID instruction reads rt
- ID_Branch  in  1  ID instruction is a conditional branch
- ID_BranchTaken  in  1  ID comparator result; valid only when no stall
- ID_Jump  in  1  ID instruction is j/jal/jr/jalr
- ID_JumpReg  in  1  ID instruction is jr/jalr (reads rs in ID)
- ID_MulDiv  in  1  ID instruction is mult/multu/div/divu
- ID_ReadHiLo  in  1  ID instruction is mfhi/mflo
- EX_MemRead  in  1  EX instruction is a load
- EX_RegWrite  in  1  EX instruction writes a register
- EX_WriteReg  in  5  EX destination register
- MEM_MemRead  in  1  MEM instruction is a load
- MEM_WriteReg  in  5  MEM destination register
- PC_Write  out  1  PC update enable
- Stall_FD  out  1  hold IF/ID register
- Flush_FD  out  1  clear IF/ID register
- Flush_DE  out  1  clear ID/EX register (bubble)
- MD_Start  out  1  one-cycle pulse: launch mult/div
- MD_Done  out  1  one-cycle pulse: HI/LO written at end of this cycle
- MD_Busy  out  1  mult/div unit occupied
- StallCount  out  CNT_W  saturating count of Stall_FD cycles
- FlushCount  out  CNT_W  saturating count of Flush_FD cycles

Behaviour:
- Hazard terms (combinational). A register match requires the register != 0 and the matching Uses* bit; rs is also read when ID_JumpReg=1.
  - lu: EX_MemRead and EX_WriteReg matches rs or rt.
  - bx: (ID_Branch or ID_JumpReg), EX_RegWrite=1, and EX_WriteReg matches.
  - bm: (ID_Branch or ID_JumpReg), MEM_MemRead=1, and MEM_WriteReg matches.
  - hl: ID_ReadHiLo and MD_Busy.
  - sd: ID_MulDiv, MD_Busy, and not MD_Done.
- stall = lu | bx | bm | hl | sd.
- Stall_FD = stall; PC_Write = !stall; Flush_DE = stall.
- A branch directly after a load produces 2 stall cycles: bx then bm. After an ALU producer it produces 1 stall cycle.
- Flush_FD = !stall & ((ID_Branch & ID_BranchTaken) | ID_Jump).
- MD_Start = ID_MulDiv & !stall.
- Mult/div FSM states: IDLE, RUN.
  - MD_Start in cycle T: next state RUN, cnt <= MD_CYCLES.
  - RUN: cnt decrements each cycle. MD_Busy = (state==RUN).
  - MD_Done = RUN & cnt==1; next state IDLE unless MD_Start in the same cycle, which reloads cnt and stays in RUN (back-to-back issue).
  - RUN spans T+1..T+MD_CYCLES. mfhi/mflo in ID stalls through T+MD_CYCLES and proceeds at T+MD_CYCLES+1.
- Counters are registered and increment on cycles where Stall_FD / Flush_FD = 1. They saturate at all-ones and never wrap.
- Reset (clk edge with reset=1): state IDLE, cnt 0, both counters 0.
  - While reset=1, outputs are forced: PC_Write=1; Stall_FD, Flush_FD, Flush_DE, MD_Start, MD_Done, MD_Busy = 0.
  - Reset mid-RUN abandons the operation; MD_Done does not pulse.
- Stall/flush outputs are combinational from inputs plus registered state, with no extra latency.

Test Plan:
- lw $8 in EX; ID add reads $8 (UsesRs) -> one cycle of Stall_FD=1, PC_Write=0, Flush_DE=1; next cycle stall=0; StallCount=1.
- lw $9 in EX; ID beq reads $9 -> 2 stall cycles (bx, then bm); third cycle ID_BranchTaken=1 -> Flush_FD=1 for 1 cycle; StallCount=2, FlushCount=1.
- EX writes $0, ID beq reads $0 -> no stall; ID j -> Flush_FD=1.
- mult issued at T (MD_Start=1); mflo in ID from T+1 -> stall for 32 cycles, MD_Done=1 at T+32, mflo proceeds at T+33, MD_Busy=0 at T+33.
- Second mult in ID during RUN -> stalled until the MD_Done cycle, where MD_Start=1 and RUN continues with cnt=32. Reset asserted at T+10 of a RUN -> MD_Busy=0 next cycle, no MD_Done pulse.
- CNT_W=4, hold a stall condition for 20 cycles -> StallCount reaches 15 and stays at 15.
